// File: rtl/router_pkg.sv
// Shared types and helpers for the mesh router.
//   port_t   : output port selector (EAST, WEST, NORTH, SOUTH, LOCAL)
//   state_t  : input-port FSM states
//   phase_t  : position inside the packet while streaming
//   xy_route : dimension-ordered (X first, then Y) route decision
package router_pkg;

  typedef enum logic [2:0] {
    EAST  = 3'd0,
    WEST  = 3'd1,
    NORTH = 3'd2,
    SOUTH = 3'd3,
    LOCAL = 3'd4
  } port_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SEND
  } state_t;

  typedef enum logic [1:0] {
    HDR,
    SIZE,
    PAYLOAD
  } phase_t;

  // dst carries the header zero-extended to 64 bits; half_w is the width of
  // each coordinate field (upper half = dst_x, lower half = dst_y).
  // All comparisons are unsigned.
  function automatic port_t xy_route(input logic [63:0] dst,
                                     input int unsigned half_w,
                                     input int unsigned x,
                                     input int unsigned y);
    logic [63:0] mask;
    logic [63:0] dst_x;
    logic [63:0] dst_y;
    mask  = (64'd1 << half_w) - 64'd1;
    dst_y = dst & mask;
    dst_x = (dst >> half_w) & mask;
    if (dst_x > 64'(x)) return EAST;
    if (dst_x < 64'(x)) return WEST;
    if (dst_y > 64'(y)) return NORTH;
    if (dst_y < 64'(y)) return SOUTH;
    return LOCAL;
  endfunction

endpackage

// File: rtl/router_input_port_if.sv
// Handshake/data bundle of one router input port.
//   rx, data_in      : upstream flit valid / flit
//   credit_o         : space available to upstream
//   req, out_port    : switch-allocator request and requested port
//   grant            : allocator grant
//   tx, data_out     : flit valid / flit toward the crossbar
//   credit_i         : downstream can accept a flit
//   overflow         : sticky drop indicator
// slave  = the input port itself, master = its environment.
interface router_input_port_if
  import router_pkg::*;
#(
  parameter int FLIT_WIDTH = 16
);
  logic                  rx;
  logic [FLIT_WIDTH-1:0] data_in;
  logic                  credit_o;
  logic                  req;
  port_t                 out_port;
  logic                  grant;
  logic                  tx;
  logic [FLIT_WIDTH-1:0] data_out;
  logic                  credit_i;
  logic                  overflow;

  modport slave (
    input  rx, data_in, grant, credit_i,
    output credit_o, req, out_port, tx, data_out, overflow
  );

  modport master (
    output rx, data_in, grant, credit_i,
    input  credit_o, req, out_port, tx, data_out, overflow
  );
endinterface

// File: rtl/flit_fifo.sv
// Flit FIFO with registered pointers and occupancy count.
//   clock, reset : clock and asynchronous active-high reset
//   wr, wr_data  : write request (ignored when full) and flit
//   rd           : pop request (ignored when empty)
//   rd_data      : head flit, 0 while empty
//   full, empty  : occupancy flags
// The head is read combinationally from the array, so a flit written in
// cycle t appears at rd_data in t+1, never in t.
module flit_fifo #(
  parameter int FLIT_WIDTH   = 16,
  parameter int BUFFER_DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [FLIT_WIDTH-1:0] wr_data,
  input  logic                  rd,
  output logic [FLIT_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);
  localparam int PTR_W = $clog2(BUFFER_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [FLIT_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic                  wr_en;
  logic                  rd_en;

  assign full  = (count_reg == CNT_W'(BUFFER_DEPTH));
  assign empty = (count_reg == '0);
  assign wr_en = wr && !full;
  assign rd_en = rd && !empty;

  assign rd_data = empty ? '0 : mem[rd_ptr_reg];

  // Storage is not reset; validity is tracked by the count.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_reg] <= wr_data;
  end

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/router_input_port.sv
// Mesh router input port: buffers incoming flits, XY-routes the header,
// requests the switch allocator and streams header, size and payload to
// the crossbar under credit flow control.
//   clock, reset : clock and asynchronous active-high reset
//   bus          : router_input_port_if slave (see interface header)
module router_input_port
  import router_pkg::*;
#(
  parameter int          FLIT_WIDTH   = 16,
  parameter int          BUFFER_DEPTH = 8,
  parameter int unsigned X_ADDR       = 0,
  parameter int unsigned Y_ADDR       = 0
) (
  input  logic               clock,
  input  logic               reset,
  router_input_port_if.slave bus
);
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_wr;
  logic [FLIT_WIDTH-1:0] head;

  state_t                state_reg, state_next;
  phase_t                phase_reg, phase_next;
  logic [FLIT_WIDTH-1:0] size_cnt_reg, size_cnt_next;
  port_t                 out_port_reg, out_port_next;
  logic                  overflow_reg;
  logic                  req_int;
  logic                  tx_int;

  assign fifo_wr = bus.rx && !fifo_full;

  flit_fifo #(
    .FLIT_WIDTH  (FLIT_WIDTH),
    .BUFFER_DEPTH(BUFFER_DEPTH)
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .wr     (fifo_wr),
    .wr_data(bus.data_in),
    .rd     (tx_int),
    .rd_data(head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      phase_reg    <= HDR;
      size_cnt_reg <= '0;
      out_port_reg <= EAST;
    end else begin
      state_reg    <= state_next;
      phase_reg    <= phase_next;
      size_cnt_reg <= size_cnt_next;
      out_port_reg <= out_port_next;
    end
  end

  // Sticky: only reset clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                     overflow_reg <= 1'b0;
    else if (bus.rx && fifo_full)  overflow_reg <= 1'b1;
  end

  always_comb begin
    state_next    = state_reg;
    phase_next    = phase_reg;
    size_cnt_next = size_cnt_reg;
    out_port_next = out_port_reg;
    req_int       = 1'b0;
    tx_int        = 1'b0;
    case (state_reg)
      IDLE: begin
        // Head of a non-empty FIFO at this point is always a header flit.
        if (!fifo_empty) begin
          out_port_next = xy_route(64'(head), FLIT_WIDTH / 2, X_ADDR, Y_ADDR);
          state_next    = REQ;
        end
      end
      REQ: begin
        req_int = 1'b1;
        if (bus.grant) begin
          state_next = SEND;
          phase_next = HDR;
        end
      end
      SEND: begin
        req_int = 1'b1;
        tx_int  = bus.grant && !fifo_empty && bus.credit_i;
        if (tx_int) begin
          case (phase_reg)
            HDR: phase_next = SIZE;
            SIZE: begin
              size_cnt_next = head;
              if (head == '0) state_next = IDLE;
              else            phase_next = PAYLOAD;
            end
            PAYLOAD: begin
              size_cnt_next = size_cnt_reg - FLIT_WIDTH'(1);
              if (size_cnt_reg == FLIT_WIDTH'(1)) state_next = IDLE;
            end
            default: phase_next = HDR;
          endcase
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.req      = req_int;
  assign bus.tx       = tx_int;
  assign bus.out_port = out_port_reg;
  assign bus.data_out = head;
  assign bus.overflow = overflow_reg;
  // Forced low while reset is asserted so upstream never sends into a
  // port that is being cleared.
  assign bus.credit_o = !fifo_full && !reset;
endmodule

// File: tb/tb_router_input_port.sv
// Self-checking bench for router_input_port (X=1, Y=1, depth 8).
module tb_router_input_port;
  import router_pkg::*;

  localparam int FW = 16;
  localparam int XA = 1;
  localparam int YA = 1;

  logic clock = 1'b0;
  logic reset = 1'b0;

  router_input_port_if #(.FLIT_WIDTH(FW)) bus();

  router_input_port #(
    .FLIT_WIDTH  (FW),
    .BUFFER_DEPTH(8),
    .X_ADDR      (XA),
    .Y_ADDR      (YA)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int           n_cmp    = 0;
  int           n_err    = 0;
  int           tx_count = 0;
  logic [FW-1:0] exp_flits[$];
  int           exp_ports[$];
  bit           rand_mode = 1'b0;
  logic         req_prev  = 1'b0;
  logic [2:0]   port_prev = 3'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference XY decision from the coordinate fields of the header.
  function automatic int ref_route(input logic [FW-1:0] hdr);
    int dx, dy;
    dx = int'(hdr[15:8]);
    dy = int'(hdr[7:0]);
    if (dx > XA) return 0;
    if (dx < XA) return 1;
    if (dy > YA) return 2;
    if (dy < YA) return 3;
    return 4;
  endfunction

  // Crossbar-side observer: flit order, tx qualification, route and
  // out_port stability.
  always @(negedge clock) begin
    logic [31:0] e;
    if (reset) begin
      req_prev = 1'b0;
    end else begin
      if (bus.tx) begin
        tx_count++;
        check("tx_needs_grant_and_credit", {30'd0, bus.grant, bus.credit_i}, 32'd3);
        e = (exp_flits.size() != 0) ? 32'(exp_flits.pop_front()) : 32'hFFFF_FFFF;
        check("flit_order", 32'(bus.data_out), e);
      end
      if (bus.req && !req_prev) begin
        e = (exp_ports.size() != 0) ? 32'(exp_ports.pop_front()) : 32'hFFFF_FFFF;
        check("out_port_route", 32'(bus.out_port), e);
      end
      if (bus.req && req_prev)
        check("out_port_stable", 32'(bus.out_port), 32'(port_prev));
      req_prev  = bus.req;
      port_prev = bus.out_port;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    if (rand_mode) begin
      bus.grant    = 1'($urandom_range(0, 1));
      bus.credit_i = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_raw(input logic [FW-1:0] f);
    bus.rx      = 1'b1;
    bus.data_in = f;
    step();
    bus.rx      = 1'b0;
  endtask

  task automatic send_flit(input logic [FW-1:0] f);
    int guard = 0;
    while (!bus.credit_o && guard < 200) begin
      step();
      guard++;
    end
    send_raw(f);
  endtask

  task automatic send_packet(input logic [FW-1:0] hdr, input int size);
    logic [FW-1:0] p;
    exp_ports.push_back(ref_route(hdr));
    exp_flits.push_back(hdr);
    exp_flits.push_back(16'(size));
    send_flit(hdr);
    send_flit(16'(size));
    for (int i = 0; i < size; i++) begin
      p = 16'($urandom);
      exp_flits.push_back(p);
      send_flit(p);
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (exp_flits.size() == 0 && exp_ports.size() == 0 && !bus.req) break;
      step();
    end
    check(tag, {30'd0, exp_flits.size() == 0, bus.req}, 32'd2);
  endtask

  initial begin
    logic [FW-1:0] f[5];
    logic [FW-1:0] pk[8];
    int base;

    bus.rx = 1'b0; bus.data_in = '0; bus.grant = 1'b0; bus.credit_i = 1'b0;

    // Reset: everything low, including credit_o while reset is held.
    #2 reset = 1'b1;
    #1;
    check("rst_credit_o", 32'(bus.credit_o), 32'd0);
    check("rst_req", 32'(bus.req), 32'd0);
    check("rst_tx", 32'(bus.tx), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("post_rst_credit_o", 32'(bus.credit_o), 32'd1);
    check("post_rst_out_port", 32'(bus.out_port), 32'd0);
    check("post_rst_data_out", 32'(bus.data_out), 32'd0);

    // Test 1: EAST packet, cycle-exact latency and back-to-back streaming.
    bus.grant = 1'b1; bus.credit_i = 1'b1;
    f[0] = 16'h0201; f[1] = 16'h0003;
    for (int i = 2; i < 5; i++) f[i] = 16'($urandom);
    exp_ports.push_back(ref_route(f[0]));
    for (int i = 0; i < 5; i++) exp_flits.push_back(f[i]);
    for (int c = 0; c <= 8; c++) begin
      check($sformatf("t1_req_c%0d", c), 32'(bus.req), (c >= 2 && c <= 7) ? 32'd1 : 32'd0);
      check($sformatf("t1_tx_c%0d", c), 32'(bus.tx), (c >= 3 && c <= 7) ? 32'd1 : 32'd0);
      if (c < 5) send_raw(f[c]);
      else       step();
    end
    wait_idle("t1_idle");

    // Test 2: LOCAL packet with zero size -> exactly two flits.
    base = tx_count;
    send_packet(16'h0101, 0);
    wait_idle("t2_idle");
    check("t2_flit_count", tx_count - base, 32'd2);

    // Test 3: WEST, NORTH, SOUTH queued back to back.
    base = tx_count;
    send_packet(16'h0001, 1);
    send_packet(16'h0102, 2);
    send_packet(16'h0100, 0);
    wait_idle("t3_idle");
    check("t3_flit_count", tx_count - base, 32'd9);

    // Test 4: fill with grant low; 9th flit dropped, overflow sticky.
    bus.grant = 1'b0;
    pk[0] = 16'h0201; pk[1] = 16'd6;
    for (int i = 2; i < 8; i++) pk[i] = 16'($urandom);
    exp_ports.push_back(ref_route(pk[0]));
    for (int i = 0; i < 8; i++) exp_flits.push_back(pk[i]);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("t4_credit_before_8th", 32'(bus.credit_o), 32'd1);
      send_raw(pk[i]);
    end
    check("t4_credit_full", 32'(bus.credit_o), 32'd0);
    check("t4_overflow_before", 32'(bus.overflow), 32'd0);
    send_raw(16'hDEAD);
    check("t4_overflow_set", 32'(bus.overflow), 32'd1);
    repeat (3) step();
    check("t4_overflow_held", 32'(bus.overflow), 32'd1);
    base = tx_count;
    bus.grant = 1'b1;
    wait_idle("t4_idle");
    check("t4_flit_count", tx_count - base, 32'd8);
    check("t4_overflow_sticky", 32'(bus.overflow), 32'd1);
    check("t4_credit_restored", 32'(bus.credit_o), 32'd1);

    // Test 5: random grant/credit_i during a 10-flit payload.
    base = tx_count;
    rand_mode = 1'b1;
    send_packet({8'($urandom_range(0, 2)), 8'($urandom_range(0, 2))}, 10);
    wait_idle("t5_idle");
    rand_mode = 1'b0;
    bus.grant = 1'b1; bus.credit_i = 1'b1;
    check("t5_flit_count", tx_count - base, 32'd12);

    // Test 6: reset after 3 of 6 payload flits, then a fresh packet.
    base = tx_count;
    send_packet(16'h0001, 6);
    for (int i = 0; i < 50 && tx_count < base + 5; i++) step();
    check("t6_sent_before_reset", tx_count - base, 32'd5);
    reset = 1'b1;
    #2;
    check("t6_rst_req", 32'(bus.req), 32'd0);
    check("t6_rst_tx", 32'(bus.tx), 32'd0);
    check("t6_rst_credit_o", 32'(bus.credit_o), 32'd0);
    exp_flits.delete();
    exp_ports.delete();
    step();
    step();
    reset = 1'b0;
    #1;
    check("t6_post_credit_o", 32'(bus.credit_o), 32'd1);
    check("t6_post_overflow", 32'(bus.overflow), 32'd0);
    check("t6_post_data_out", 32'(bus.data_out), 32'd0);
    repeat (3) step();
    check("t6_post_req", 32'(bus.req), 32'd0);
    check("t6_post_tx", 32'(bus.tx), 32'd0);
    base = tx_count;
    send_packet(16'h0102, 2);
    wait_idle("t6_idle");
    check("t6_flit_count", tx_count - base, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
